cnn_conv_acc_relu: RTL and testbench
====================================

// Module: cnn_conv_acc_relu
// PURPOSE
//   Downstream consumer of the conv-layer signed product stage (10s x 14s -> 24-bit products).
//   Accumulates N_TERMS products per output pixel, seeded with a per-channel bias.
//   Then rounds, shifts, saturates and applies ReLU.
//   Emits one OUT_W-bit activation per window over a valid/ready handshake to the next layer.
// PARAMETERS
//   PROD_W  24  signed product width (from multiplier)
//   ACC_W   32  signed accumulator width
//   N_TERMS 9   products per output (3x3 kernel); legal range 1..255
//   BIAS_W  16  signed bias width
//   SHIFT   8   fractional bits removed on output; SHIFT >= 1
//   OUT_W   16  signed output width
// PORTS
//   ap_clk     in   1        clock; all logic rising-edge
//   ap_rst     in   1        synchronous active-high reset
//   prod_valid in   1        product valid
//   prod_ready out  1        stage accepts product
//   prod_data  in   PROD_W   signed product
//   bias       in   BIAS_W   signed bias; sampled with first product of window
//   out_valid  out  1        result valid
//   out_ready  in   1        downstream accepts result
//   out_data   out  OUT_W    ReLU'd, saturated activation (always >= 0)
//   out_sat    out  1        out_data was clipped to max positive
//   busy       out  1        window partially accumulated (term count != 0)
// BEHAVIOUR
//   Reset (ap_rst=1 at edge):
//     - term count=0, acc=0, out_valid=0, out_data=0, out_sat=0, state=ACC.
//     - A partial window is discarded. prod_ready=0 while ap_rst=1.
//   Product accept (xfer): prod_valid & prod_ready at a rising edge.
//   prod_ready = ~out_valid (single output register). No same-cycle accept while a result is held.
//   States:
//     ACC:
//       - On xfer with count==0: acc = (sext(bias) <<< SHIFT) + sext(prod_data).
//       - Other xfers: acc = acc + sext(prod_data).
//       - Count increments per xfer. Accumulator wraps modulo 2^ACC_W; no overflow detection.
//       - On xfer with count==N_TERMS-1: count<=0, result computed from the final sum
//         (incl. this product), state<=OUT.
//     OUT:
//       - out_valid=1; out_data/out_sat held stable until out_ready.
//       - On out_valid & out_ready: out_valid<=0, state<=ACC. Next product is accepted the following cycle at earliest.
//   Result arithmetic (combinational on final sum s, registered into out_data):
//     - r = (s + 2^(SHIFT-1)) >>> SHIFT. Arithmetic shift: round-half-up toward +inf.
//     - r > 2^(OUT_W-1)-1  -> out_data = 2^(OUT_W-1)-1, out_sat = 1.
//     - r < 0              -> out_data = 0, out_sat = 0 (ReLU).
//     - Else               -> out_data = r, out_sat = 0.
//   Latency: out_valid asserts the cycle after the last product xfer.
//   Throughput: max one result per N_TERMS+1 cycles.
//   Gaps: prod_valid may drop at any point mid-window; acc and count hold.
//   Bias: ignored on all but the first xfer of a window.
//   Reset mid-operation (either state): behaves as reset above; a held result is lost.
// TESTING
//   - 9x prod=256, bias=2 -> acc=2816, out_data=11, out_sat=0; out_valid 1 cycle after 9th xfer.
//   - 9x prod=-512, bias=0 -> r=-18 -> out_data=0, out_sat=0.
//   - 9x prod=8388607, bias=32767 -> out_data=32767, out_sat=1.
//   - Rounding: bias=0, prods {128,0x8} -> out_data=1; prods {127,0x8} -> out_data=0.
//   - Backpressure: out_ready=0 for 5 cycles with prod_valid=1 -> prod_ready=0, out_data stable,
//     no products consumed. Then out_ready=1 -> next window's first product accepted the next cycle.
//   - Reset mid-window: 4 xfers, ap_rst 1 cycle, then 9x prod=256 bias=0 -> out_data=9 (partial discarded).
//   - Bubbles: random prod_valid gaps over 9 terms -> same result as the gapless case.

Source files
------------

// File: rtl/cnn_conv_acc_relu.sv
// Conv-layer accumulator: bias-seeded sum of N_TERMS signed products, then
// round-half-up, shift, saturate and ReLU into a single valid/ready output register.
module cnn_conv_acc_relu #(
  parameter int PROD_W  = 24,
  parameter int ACC_W   = 32,
  parameter int N_TERMS = 9,
  parameter int BIAS_W  = 16,
  parameter int SHIFT   = 8,
  parameter int OUT_W   = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic [BIAS_W-1:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              busy
);

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  localparam logic [7:0]              LAST = 8'(N_TERMS - 1);
  localparam logic signed [ACC_W:0]   HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_W:0]   MAXP = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};

  state_t                   state;
  logic [7:0]               count;
  logic signed [ACC_W-1:0]  acc;
  logic                     xfer;
  logic signed [ACC_W-1:0]  prod_ext, bias_ext, base, sum;
  logic signed [ACC_W:0]    rnd, r;
  logic [OUT_W-1:0]         res_data;
  logic                     res_sat;

  assign prod_ready = ~out_valid & ~ap_rst;
  assign xfer       = prod_valid & prod_ready;
  assign busy       = (count != '0);

  // Rounding is done one bit wider than the accumulator so the +half cannot wrap.
  always_comb begin
    prod_ext = {{(ACC_W - PROD_W){prod_data[PROD_W-1]}}, prod_data};
    bias_ext = {{(ACC_W - BIAS_W){bias[BIAS_W-1]}}, bias};
    base     = (count == '0) ? (bias_ext <<< SHIFT) : acc;
    sum      = base + prod_ext;
    rnd      = {sum[ACC_W-1], sum} + HALF;
    r        = rnd >>> SHIFT;
    res_data = '0;
    res_sat  = 1'b0;
    if (r > MAXP) begin
      res_data = MAXP[OUT_W-1:0];
      res_sat  = 1'b1;
    end else if (!r[ACC_W]) begin
      res_data = r[OUT_W-1:0];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= ST_ACC;
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (xfer) begin
            acc <= sum;
            if (count == LAST) begin
              count     <= '0;
              out_data  <= res_data;
              out_sat   <= res_sat;
              out_valid <= 1'b1;
              state     <= ST_OUT;
            end else begin
              count <= count + 8'd1;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_conv_acc_relu.sv
// Randomized bench for cnn_conv_acc_relu: integer reference model, scoreboard
// queue, per-cycle output compare, plus directed literal cases.
module tb_cnn_conv_acc_relu;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        prod_valid = 1'b0;
  logic        prod_ready;
  logic [23:0] prod_data = '0;
  logic [15:0] bias = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int exp_data_q[$];
  int exp_sat_q[$];
  int rdy_rand = 0;
  int rdy_val = 1;
  logic       held = 1'b0;
  logic [15:0] held_data = '0;

  cnn_conv_acc_relu #(
    .PROD_W(24), .ACC_W(32), .N_TERMS(9), .BIAS_W(16), .SHIFT(8), .OUT_W(16)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
    .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, 32-bit wrap, round half up, clamp, ReLU.
  function automatic void model(input int b, input int p[9], output int d, output int s);
    longint acc, r;
    acc = longint'(b) * 256;
    for (int k = 0; k < 9; k++) acc += p[k];
    acc = acc & 64'hFFFF_FFFF;
    if (acc >= 64'sh8000_0000) acc -= 64'sh1_0000_0000;
    r = (acc + 128) >>> 8;
    if (r > 32767) begin d = 32767; s = 1; end
    else if (r < 0) begin d = 0; s = 0; end
    else begin d = int'(r); s = 0; end
  endfunction

  // Drives n_send products of one window; pushes the expected result when the window closes.
  task automatic send_window(input int b, input int p[9], input int n_send,
                             input int gap_pct, output int cycles);
    int i = 0;
    logic x;
    int d, s;
    cycles = 0;
    while (i < n_send) begin
      prod_valid = ($urandom_range(99) >= gap_pct);
      prod_data  = 24'(p[i]);
      bias       = (i == 0) ? 16'(b) : 16'($urandom);
      @(negedge ap_clk);
      x = prod_valid & prod_ready;
      @(posedge ap_clk);
      #1;
      cycles++;
      if (x) begin
        if (i == 8) begin
          model(b, p, d, s);
          exp_data_q.push_back(d);
          exp_sat_q.push_back(s);
          chk("latency_out_valid", out_valid, 1);
        end
        i++;
      end
      if (cycles > 3000) begin
        chk("window_timeout", i, n_send);
        break;
      end
    end
    prod_valid = 1'b0;
  endtask

  function automatic void fill(output int p[9], input int v);
    for (int k = 0; k < 9; k++) p[k] = v;
  endfunction

  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      out_ready = (rdy_rand != 0) ? ($urandom_range(3) != 0) : (rdy_val != 0);
    end
  end

  // Per-cycle compare against the scoreboard; out_data must hold while stalled.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      chk("prod_ready_vs_out_valid", prod_ready, !out_valid);
      if (out_valid) begin
        if (exp_data_q.size() == 0) begin
          chk("unexpected_result", out_valid, 0);
        end else begin
          chk("out_data", out_data, exp_data_q[0]);
          chk("out_sat", out_sat, exp_sat_q[0]);
          if (held) chk("out_data_stable", out_data, held_data);
          if (out_ready) begin
            void'(exp_data_q.pop_front());
            void'(exp_sat_q.pop_front());
          end
        end
      end
      held = out_valid & ~out_ready;
      held_data = out_data;
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    int p[9];
    int cyc, m, b, guard;

    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_prod_ready", prod_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("post_rst_prod_ready", prod_ready, 1);
    @(posedge ap_clk);
    #1;

    fill(p, 256);
    send_window(2, p, 9, 0, cyc);
    chk("basic_data", out_data, 11);
    chk("basic_sat", out_sat, 0);
    chk("basic_cycles", cyc, 9);
    @(posedge ap_clk); #1;

    fill(p, -512);
    send_window(0, p, 9, 0, cyc);
    chk("relu_data", out_data, 0);
    chk("relu_sat", out_sat, 0);
    @(posedge ap_clk); #1;

    fill(p, 8388607);
    send_window(32767, p, 9, 0, cyc);
    chk("sat_data", out_data, 32767);
    chk("sat_flag", out_sat, 1);
    @(posedge ap_clk); #1;

    fill(p, 0); p[0] = 128;
    send_window(0, p, 9, 0, cyc);
    chk("round_up", out_data, 1);
    @(posedge ap_clk); #1;
    p[0] = 127;
    send_window(0, p, 9, 0, cyc);
    chk("round_down", out_data, 0);
    @(posedge ap_clk); #1;

    // Backpressure: result held, next window's product refused.
    rdy_val = 0;
    @(posedge ap_clk); #1;
    fill(p, 256);
    send_window(2, p, 9, 0, cyc);
    prod_valid = 1'b1; prod_data = 24'd256; bias = 16'd0;
    repeat (5) begin
      @(negedge ap_clk);
      chk("bp_prod_ready", prod_ready, 0);
      chk("bp_out_data", out_data, 11);
      chk("bp_busy", busy, 0);
    end
    prod_valid = 1'b0;
    rdy_val = 1;
    guard = 0;
    do begin
      @(negedge ap_clk);
      guard++;
    end while (out_valid && guard < 20);
    chk("bp_release_ready", prod_ready, 1);
    @(posedge ap_clk); #1;
    send_window(0, p, 9, 0, cyc);
    chk("bp_next_cycles", cyc, 9);
    chk("bp_next_data", out_data, 9);
    @(posedge ap_clk); #1;

    // Reset mid-window discards the partial sum.
    send_window(100, p, 4, 0, cyc);
    chk("partial_busy", busy, 1);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    chk("mid_rst_prod_ready", prod_ready, 0);
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    send_window(0, p, 9, 0, cyc);
    chk("after_rst_data", out_data, 9);
    @(posedge ap_clk); #1;

    send_window(2, p, 9, 50, cyc);
    chk("bubbles_data", out_data, 11);
    @(posedge ap_clk); #1;

    // Random windows with random gaps and random backpressure.
    rdy_rand = 1;
    for (int w = 0; w < 150; w++) begin
      case ($urandom_range(2))
        0: m = 1024;
        1: m = 32768;
        default: m = 8388607;
      endcase
      for (int k = 0; k < 9; k++) p[k] = int'($urandom_range(0, 2 * m)) - m;
      b = int'($signed(16'($urandom)));
      send_window(b, p, 9, 30, cyc);
    end
    rdy_rand = 0;
    rdy_val = 1;
    guard = 0;
    while (exp_data_q.size() != 0 && guard < 50) begin
      @(posedge ap_clk);
      guard++;
    end
    chk("scoreboard_drained", exp_data_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
